// File: rtl/chan_tx_arbiter.sv
// Round-robin arbiter sharing one tx chain among NUM_CHAN packet readers.
// A grant is held across a whole burst and muxes the owner's I/Q/empty onto the chain.
module chan_tx_arbiter #(
    parameter int          NUM_CHAN   = 4,
    parameter logic [31:0] MAX_HOLD   = 32'd65536,
    parameter logic [3:0]  GAP_CYCLES = 4'd2
) (
    input  logic                     tx_clock,
    input  logic                     reset,
    input  logic [NUM_CHAN-1:0]      pkt_waiting_in,
    input  logic [NUM_CHAN-1:0]      skip_in,
    input  logic [NUM_CHAN-1:0]      burst_in,
    input  logic [NUM_CHAN-1:0]      tx_empty_in,
    input  logic [16*NUM_CHAN-1:0]   tx_i_in,
    input  logic [16*NUM_CHAN-1:0]   tx_q_in,
    output logic [NUM_CHAN-1:0]      pkt_waiting_out,
    output logic [NUM_CHAN-1:0]      grant,
    output logic [2:0]               owner,
    output logic [15:0]              tx_i,
    output logic [15:0]              tx_q,
    output logic                     tx_empty,
    output logic                     timeout,
    output logic [15:0]              debug
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    logic [1:0]          state;
    logic [31:0]         hold_cnt;
    logic [3:0]          gap_cnt;
    logic                any_req;
    logic                sel_found;
    logic [2:0]          sel_idx;
    logic [NUM_CHAN-1:0] sel_onehot;
    logic                own_skip;
    logic                own_burst;
    logic                own_empty;
    logic [15:0]         own_i;
    logic [15:0]         own_q;
    logic                hold_expired;

    assign any_req         = |pkt_waiting_in;
    assign pkt_waiting_out = pkt_waiting_in & grant;
    assign hold_expired    = (MAX_HOLD != 32'd0) && (hold_cnt == MAX_HOLD - 32'd1);
    assign debug           = {8'(grant), owner, state, hold_expired, any_req, 1'b0};

    // Scan owner+1, owner+2, ... so the last owner has lowest priority.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = owner;
        sel_onehot = '0;
        for (int i = 1; i <= NUM_CHAN; i++) begin
            for (int k = 0; k < NUM_CHAN; k++) begin
                if (!sel_found && pkt_waiting_in[k] && (((int'(owner) + i) % NUM_CHAN) == k)) begin
                    sel_found = 1'b1;
                    sel_idx   = 3'(k);
                end
            end
        end
        for (int k = 0; k < NUM_CHAN; k++) begin
            sel_onehot[k] = (sel_idx == 3'(k));
        end
    end

    always_comb begin
        own_skip  = 1'b0;
        own_burst = 1'b0;
        own_empty = 1'b1;
        own_i     = '0;
        own_q     = '0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            if (int'(owner) == k) begin
                own_skip  = skip_in[k];
                own_burst = burst_in[k];
                own_empty = tx_empty_in[k];
                own_i     = tx_i_in[16*k +: 16];
                own_q     = tx_q_in[16*k +: 16];
            end
        end
    end

    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= 3'(NUM_CHAN - 1);
            hold_cnt <= '0;
            gap_cnt  <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant    <= sel_onehot;
                        owner    <= sel_idx;
                        hold_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != 32'hFFFF_FFFF) begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                    // A skip always takes precedence over the hold timeout.
                    if (own_skip && own_burst) begin
                        hold_cnt <= '0;
                    end else if (own_skip) begin
                        grant <= '0;
                        state <= ST_RELEASE;
                    end else if (hold_expired) begin
                        grant   <= '0;
                        timeout <= 1'b1;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    grant   <= '0;
                    gap_cnt <= GAP_CYCLES;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register stage: one cycle behind the registered grant.
    always_ff @(posedge tx_clock or negedge reset) begin
        if (!reset) begin
            tx_i     <= '0;
            tx_q     <= '0;
            tx_empty <= 1'b1;
        end else if (|grant) begin
            tx_i     <= own_i;
            tx_q     <= own_q;
            tx_empty <= own_empty;
        end else begin
            tx_i     <= '0;
            tx_q     <= '0;
            tx_empty <= 1'b1;
        end
    end

endmodule

// File: doc/chan_tx_arbiter.md
Name: chan_tx_arbiter

Overview:
- Shares the single tx chain among NUM_CHAN channel FIFO readers.
- Gates each reader's pkt_waiting so only one reader runs at a time. Grants round-robin, and a grant is atomic over a full burst (start-of-burst through end-of-burst).
- Muxes the owner's tx_i/tx_q/tx_empty onto the tx chain.
- Sits between the per-channel packet FIFOs/readers and the tx_chain.

Parameters:
NUM_CHAN, 4, number of channels; legal 2..8
MAX_HOLD, 32'd65536, tx_clock cycles a grant may be held without a packet completing; 0 disables the timeout
GAP_CYCLES, 4'd2, idle cycles inserted after each release before re-arbitration

Ports:
tx_clock  in  1  system tx clock; all logic on its rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
pkt_waiting_in  in  NUM_CHAN  per-channel packet-ready from the FIFOs
skip_in  in  NUM_CHAN  per-reader skip pulse (packet finished or discarded)
burst_in  in  NUM_CHAN  per-reader burst flag (1 = inside a burst)
tx_empty_in  in  NUM_CHAN  per-reader tx_empty
tx_i_in  in  16*NUM_CHAN  per-reader I; channel k occupies bits [16k+15:16k]
tx_q_in  in  16*NUM_CHAN  per-reader Q, same packing
pkt_waiting_out  out  NUM_CHAN  gated pkt_waiting to the readers
grant  out  NUM_CHAN  one-hot grant, registered; all-zero when no owner
owner  out  3  index of the current or last owner
tx_i  out  16  muxed I to the tx_chain, registered
tx_q  out  16  muxed Q, registered
tx_empty  out  1  muxed tx_empty, registered
timeout  out  1  one-cycle pulse on a forced release
debug  out  16  {grant[7:0] zero-extended, owner, state[1:0], hold_expired, any_req, 1'b0}

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; grant=0; owner=NUM_CHAN-1, so channel 0 wins first; tx_i=0; tx_q=0; tx_empty=1; timeout=0.
  - Hold counter and gap counter cleared.
  - Reset mid-grant drops the grant immediately.
- pkt_waiting_out = pkt_waiting_in & grant. Combinational from the registered grant.
- States:
  - IDLE: if any pkt_waiting_in bit is set, select the first set bit scanning owner+1, owner+2, ... modulo NUM_CHAN. Register grant=onehot(sel) and owner=sel, clear the hold counter, go to GRANT. No request: stay in IDLE. Channel selection to grant high takes 1 cycle.
  - GRANT: hold counter increments each cycle, saturating at 2^32-1.
    - skip_in[owner]=1 with burst_in[owner]=1: stay in GRANT and clear the hold counter (burst continues).
    - skip_in[owner]=1 with burst_in[owner]=0: go to RELEASE.
    - Otherwise, MAX_HOLD!=0 and hold counter == MAX_HOLD-1: go to RELEASE and pulse timeout for 1 cycle.
    - If skip and timeout occur in the same cycle, skip wins and timeout is not pulsed.
    - skip_in on non-owner channels is ignored.
  - RELEASE: grant=0, load the gap counter with GAP_CYCLES, go to GAP. owner is retained as the round-robin pointer.
  - GAP: decrement the gap counter; go to IDLE when it reads 0. GAP_CYCLES=0 means GAP lasts 1 cycle.
- Datapath, 1-cycle registered latency:
  - When grant!=0: tx_i/tx_q/tx_empty take the owner's inputs.
  - Otherwise: tx_i=0, tx_q=0, tx_empty=1.
- pkt_waiting_in may drop before a grant; arbitration re-evaluates every IDLE cycle with no memory of prior requests.
- The grant is never given to a channel whose pkt_waiting_in was 0 in the IDLE decision cycle.
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,3,0,...

Test Plan:
- Reset release with pkt_waiting_in=4'b0101 -> grant=4'b0001 one cycle after reset deasserts. ch0 skips with burst=0 -> release, then GAP_CYCLES+1 cycles later grant=4'b0100.
- All four requesting, each finishing single-packet bursts -> grant sequence 0001,0010,0100,1000,0001; pkt_waiting_out only ever has the owner's bit set.
- ch1 owner, skip pulses with burst_in[1]=1 three times, then skip with burst_in[1]=0 -> grant holds 4'b0010 until the final skip. ch2 requesting throughout is not granted until that release.
- MAX_HOLD=16, ch3 owner never skips -> timeout pulses exactly once, 16 cycles after the grant; grant clears, and other requesters are served afterwards.
- ch0 owner with tx_i_in[15:0]=16'h1234, tx_q_in[15:0]=16'hABCD, tx_empty_in[0]=0, while ch1 drives 16'hFFFF -> tx_i=16'h1234 and tx_q=16'hABCD one cycle later. In GAP: tx_i=0, tx_empty=1.
- reset asserted low mid-GRANT (asynchronously, between clock edges) -> grant=0 and tx_empty=1 without waiting for a clock edge. After release, arbitration restarts from channel 0.
